cpu_step_controller: RTL and testbench

Clock-enable generator that sits directly upstream of the single-cycle CPU core and decides when the core advances. It debounces the raw step push-button and run switch, then issues one-cycle `cpu_clk_en` pulses in two modes: single-step (one pulse per press) or free-run (one pulse every `RUN_DIV` cycles). Free-run halts on a PC breakpoint. `cpu_clk_en` drives the clock enable of every state element in the core: PC, register file and data-memory write.

---
 rtl/cpu_step_if.sv | 54 +++++
 rtl/cpu_step_controller.sv | 209 ++++++++++++++++++++
 tb/tb_cpu_step_controller.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_step_if.sv
// ---------------------------------------------------------------------------
// cpu_step_if
//
// Bundles the signals exchanged between the step controller, the front-panel
// inputs and the CPU core.
//
//   step_btn_n  raw step push-button, active-low, asynchronous
//   run_sw      raw run slide switch, asynchronous (1 = free-run)
//   bp_en       breakpoint enable (static)
//   bp_addr     breakpoint PC (static)
//   pc_addr     current PC reported by the core
//   cpu_clk_en  one-cycle advance pulse for every state element of the core
//   running     high while the controller is free-running
//   halted      high while the controller sits on a breakpoint
//   step_count  number of cpu_clk_en pulses issued (wraps)
//
// slave  : the step controller's view.
// master : the view of whatever drives the inputs and observes the outputs.
// ---------------------------------------------------------------------------
interface cpu_step_if;
  logic        step_btn_n;
  logic        run_sw;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc_addr;
  logic        cpu_clk_en;
  logic        running;
  logic        halted;
  logic [31:0] step_count;

  modport slave (
    input  step_btn_n,
    input  run_sw,
    input  bp_en,
    input  bp_addr,
    input  pc_addr,
    output cpu_clk_en,
    output running,
    output halted,
    output step_count
  );

  modport master (
    output step_btn_n,
    output run_sw,
    output bp_en,
    output bp_addr,
    output pc_addr,
    input  cpu_clk_en,
    input  running,
    input  halted,
    input  step_count
  );
endinterface

// File: rtl/cpu_step_controller.sv
// ---------------------------------------------------------------------------
// cpu_step_controller
//
// Clock-enable generator placed in front of the single-cycle CPU core. The
// raw step button and run switch are synchronised and debounced; the
// controller then issues one-cycle cpu_clk_en pulses either once per button
// press (single-step) or once every RUN_DIV cycles (free-run). Free-run stops
// in HALT when the PC reaches an enabled breakpoint, before that instruction
// executes; a step press from HALT executes it.
//
// Parameters
//   DEBOUNCE_CYCLES  stable synchronised samples needed to accept a change
//   RUN_DIV          cycles between free-run pulses (>= 2)
//
// Ports
//   clk    system clock (only clock)
//   reset  asynchronous, active-high reset
//   bus    cpu_step_if.slave: raw inputs, breakpoint, PC in; pulse and
//          status out (all outputs registered)
// ---------------------------------------------------------------------------
module cpu_step_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV         = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  cpu_step_if.slave  bus
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DIV_W = $clog2(RUN_DIV);

  localparam logic [DB_W-1:0]  DB_LIMIT = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Stage p0/p1: two-flop synchronisers for the asynchronous panel inputs
  // -------------------------------------------------------------------------
  logic btn_sync_p0, btn_sync_p1;
  logic run_sync_p0, run_sync_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_sync_p0 <= 1'b1;
      btn_sync_p1 <= 1'b1;
      run_sync_p0 <= 1'b0;
      run_sync_p1 <= 1'b0;
    end else begin
      btn_sync_p0 <= bus.step_btn_n;
      btn_sync_p1 <= btn_sync_p0;
      run_sync_p0 <= bus.run_sw;
      run_sync_p1 <= run_sync_p0;
    end
  end

  // -------------------------------------------------------------------------
  // Debounce: the counter only advances while the synchronised input
  // disagrees with the accepted level; any agreeing sample restarts it, so a
  // glitch shorter than DEBOUNCE_CYCLES never reaches the accepted level.
  // -------------------------------------------------------------------------
  logic            btn_db;
  logic [DB_W-1:0] btn_cnt;
  logic            run_db;
  logic [DB_W-1:0] run_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_db  <= 1'b1;
      btn_cnt <= '0;
    end else if (btn_sync_p1 == btn_db) begin
      btn_cnt <= '0;
    end else if (btn_cnt == DB_LIMIT) begin
      btn_db  <= btn_sync_p1;
      btn_cnt <= '0;
    end else begin
      btn_cnt <= btn_cnt + DB_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_db  <= 1'b0;
      run_cnt <= '0;
    end else if (run_sync_p1 == run_db) begin
      run_cnt <= '0;
    end else if (run_cnt == DB_LIMIT) begin
      run_db  <= run_sync_p1;
      run_cnt <= '0;
    end else begin
      run_cnt <= run_cnt + DB_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Press detect: one-cycle request on the debounced press (1 -> 0)
  // -------------------------------------------------------------------------
  logic btn_db_d;
  logic step_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_db_d <= 1'b1;
      step_req <= 1'b0;
    end else begin
      btn_db_d <= btn_db;
      step_req <= btn_db_d & ~btn_db;
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM: state register, next-state logic, output logic
  // -------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             pulse_q, pulse_d;
  logic             running_q, running_d;
  logic             halted_q, halted_d;
  logic [31:0]      step_count_q;

  logic bp_hit;
  logic div_wrap;

  // The breakpoint compares against the PC of the instruction about to
  // execute, so a hit suppresses the pulse that would have executed it.
  assign bp_hit   = bus.bp_en && (bus.pc_addr == bus.bp_addr);
  assign div_wrap = (state_q == RUN) && (div_q == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      div_q        <= '0;
      pulse_q      <= 1'b0;
      running_q    <= 1'b0;
      halted_q     <= 1'b0;
      step_count_q <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      pulse_q   <= pulse_d;
      running_q <= running_d;
      halted_q  <= halted_d;
      if (pulse_d) begin
        step_count_q <= step_count_q + 32'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // Run switch wins over a coincident step press.
        if (run_db) begin
          state_d = RUN;
        end else if (step_req) begin
          state_d = STEP;
        end
      end
      STEP: begin
        // Always back through IDLE; IDLE re-enters RUN if the switch is on.
        state_d = IDLE;
      end
      RUN: begin
        // Step presses are deliberately ignored while free-running.
        if (!run_db) begin
          state_d = IDLE;
        end else if (div_wrap && bp_hit) begin
          state_d = HALT;
        end
      end
      HALT: begin
        if (!run_db) begin
          state_d = IDLE;
        end else if (step_req) begin
          state_d = STEP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // Divider only runs while staying in RUN, so every entry starts from 0.
    div_d = '0;
    if ((state_q == RUN) && (state_d == RUN) && !div_wrap) begin
      div_d = div_q + DIV_W'(1);
    end

    // A free-run pulse needs a wrap that is neither cut short by the run
    // switch dropping nor blocked by the breakpoint; STEP always pulses.
    pulse_d   = (state_d == STEP) ||
                (div_wrap && run_db && !bp_hit);
    running_d = (state_d == RUN);
    halted_d  = (state_d == HALT);
  end

  assign bus.cpu_clk_en = pulse_q;
  assign bus.running    = running_q;
  assign bus.halted     = halted_q;
  assign bus.step_count = step_count_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// ---------------------------------------------------------------------------
// tb_cpu_step_controller
//
// Scoreboard bench for cpu_step_controller with DEBOUNCE_CYCLES=4, RUN_DIV=8.
// Stimulus pushes the expected pulses (edge number, step_count, PC) into a
// queue; a monitor pops one entry for every cpu_clk_en pulse it observes.
// The PC model advances by 4 on every pulse and clears on reset.
//
// Edge numbering: cyc counts rising edges. An input changed at the falling
// edge where cyc == n is first sampled on edge n+1. Hand-derived latencies:
//   debounced level flips on edge n+7, step_req on n+8, STEP/pulse on n+9;
//   run switch on -> RUN entered on n+8, pulses on n+16, n+24, ...
// ---------------------------------------------------------------------------
module tb_cpu_step_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int          cyc;
    logic [31:0] cnt;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];

  cpu_step_if bus();

  cpu_step_controller #(
    .DEBOUNCE_CYCLES(4),
    .RUN_DIV        (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) cyc <= cyc + 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= 32'd0;
    else if (bus.cpu_clk_en) pc <= pc + 32'd4;
  end

  assign bus.pc_addr = pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input int c, input logic [31:0] cnt, input logic [31:0] p);
    exp_t e;
    e.cyc = c;
    e.cnt = cnt;
    e.pc  = p;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  initial begin
    logic prev_en;
    exp_t e;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && bus.cpu_clk_en) begin
        check("pulse_spacing", {31'd0, prev_en}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: pulse at edge %0d, step_count 0x%0h, none expected",
                   cyc, bus.step_count);
        end else begin
          e = exp_q.pop_front();
          check("pulse_edge", cyc, e.cyc);
          check("pulse_step_count", bus.step_count, e.cnt);
          check("pulse_pc", pc, e.pc);
        end
      end
      prev_en = bus.cpu_clk_en;
    end
  end

  initial begin
    int n;
    int p;
    int r;
    int m;

    reset          = 1'b1;
    bus.step_btn_n = 1'b1;
    bus.run_sw     = 1'b0;
    bus.bp_en      = 1'b0;
    bus.bp_addr    = 32'd0;

    // Reset and quiet idle
    repeat (3) @(negedge clk);
    check("rst_clk_en", {31'd0, bus.cpu_clk_en}, 32'd0);
    check("rst_running", {31'd0, bus.running}, 32'd0);
    check("rst_halted", {31'd0, bus.halted}, 32'd0);
    check("rst_step_count", bus.step_count, 32'd0);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    check("idle_step_count", bus.step_count, 32'd0);
    check("idle_running", {31'd0, bus.running}, 32'd0);

    // Short glitch is filtered
    bus.step_btn_n = 1'b0;
    repeat (3) @(negedge clk);
    bus.step_btn_n = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_step_count", bus.step_count, 32'd0);

    // Clean press -> one pulse at edge n+9
    n = cyc;
    expect_pulse(n + 9, 32'd1, 32'h0);
    bus.step_btn_n = 1'b0;
    repeat (12) @(negedge clk);
    bus.step_btn_n = 1'b1;
    repeat (20) @(negedge clk);
    check("press1_step_count", bus.step_count, 32'd1);

    // Release and press again
    n = cyc;
    expect_pulse(n + 9, 32'd2, 32'h4);
    bus.step_btn_n = 1'b0;
    repeat (12) @(negedge clk);
    bus.step_btn_n = 1'b1;
    repeat (20) @(negedge clk);
    check("press2_step_count", bus.step_count, 32'd2);

    // Free-run: RUN at n+8, five pulses every 8 edges
    n = cyc;
    for (int k = 0; k < 5; k++)
      expect_pulse(n + 16 + 8 * k, 32'(3 + k), 32'(8 + 4 * k));
    bus.run_sw = 1'b1;
    wait_until(n + 7);
    check("run_not_yet", {31'd0, bus.running}, 32'd0);
    wait_until(n + 8);
    check("run_entered", {31'd0, bus.running}, 32'd1);

    // Step press while running is ignored
    wait_until(n + 20);
    bus.step_btn_n = 1'b0;
    repeat (12) @(negedge clk);
    bus.step_btn_n = 1'b1;

    // Drop run right after the 5th pulse: the stop lands on the same edge
    // as the next divider wrap (n+56) and must suppress that pulse.
    wait_until(n + 48);
    bus.run_sw = 1'b0;
    wait_until(n + 55);
    check("run_still", {31'd0, bus.running}, 32'd1);
    wait_until(n + 56);
    check("run_stopped", {31'd0, bus.running}, 32'd0);
    repeat (30) @(negedge clk);
    check("run_step_count", bus.step_count, 32'd7);
    check("run_queue_empty", 32'(exp_q.size()), 32'd0);

    // Breakpoint at 0x0C from a fresh reset
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("bp_rst_step_count", bus.step_count, 32'd0);
    bus.bp_en   = 1'b1;
    bus.bp_addr = 32'h0000_000C;
    n = cyc;
    expect_pulse(n + 16, 32'd1, 32'h0);
    expect_pulse(n + 24, 32'd2, 32'h4);
    expect_pulse(n + 32, 32'd3, 32'h8);
    bus.run_sw = 1'b1;
    wait_until(n + 39);
    check("bp_not_halted", {31'd0, bus.halted}, 32'd0);
    wait_until(n + 40);
    check("bp_halted", {31'd0, bus.halted}, 32'd1);
    check("bp_not_running", {31'd0, bus.running}, 32'd0);
    repeat (40) @(negedge clk);
    check("bp_still_halted", {31'd0, bus.halted}, 32'd1);
    check("bp_step_count", bus.step_count, 32'd3);

    // Step from HALT executes 0x0C, then free-run resumes from 0x10
    p = cyc;
    expect_pulse(p + 9, 32'd4, 32'hC);
    expect_pulse(p + 19, 32'd5, 32'h10);
    expect_pulse(p + 27, 32'd6, 32'h14);
    bus.step_btn_n = 1'b0;
    wait_until(p + 10);
    check("bp_step_unhalted", {31'd0, bus.halted}, 32'd0);
    wait_until(p + 11);
    check("bp_rerun", {31'd0, bus.running}, 32'd1);
    wait_until(p + 12);
    bus.step_btn_n = 1'b1;

    // Reset mid-run with the divider at 5
    wait_until(p + 32);
    reset = 1'b1;
    #1;
    check("midrst_clk_en", {31'd0, bus.cpu_clk_en}, 32'd0);
    check("midrst_running", {31'd0, bus.running}, 32'd0);
    check("midrst_step_count", bus.step_count, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    r = cyc;
    expect_pulse(r + 16, 32'd1, 32'h0);
    expect_pulse(r + 24, 32'd2, 32'h4);
    expect_pulse(r + 32, 32'd3, 32'h8);
    wait_until(r + 7);
    check("midrst_not_running", {31'd0, bus.running}, 32'd0);
    wait_until(r + 8);
    check("midrst_rerun", {31'd0, bus.running}, 32'd1);
    wait_until(r + 40);
    check("midrst_halted", {31'd0, bus.halted}, 32'd1);

    // Dropping run leaves HALT
    m = cyc;
    bus.run_sw = 1'b0;
    wait_until(m + 8);
    check("halt_exit", {31'd0, bus.halted}, 32'd0);
    repeat (10) @(negedge clk);
    check("final_step_count", bus.step_count, 32'd3);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
